debounced_inverter: RTL and testbench

Parametrised, clocked switch-to-LED driver for the board I/O path: WIDTH independent channels, each with a two-flop synchroniser, a counter-based debouncer and a registered output stage. Selectable modes are pass-through, inverted, toggle-on-press and inverted toggle. It replaces the bare combinational NOT gate between slide/push switches and LEDs. It also provides a one-cycle press strobe per channel for downstream counters and FSMs.

---
 rtl/debounced_inverter.sv | 110 +++++++++++
 tb/tb_debounced_inverter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_inverter.sv
// debounced_inverter: per-channel switch conditioning for the board I/O path.
// Each channel has a two-flop synchroniser, a counter-based debouncer, a press
// toggle and a registered LED/press output stage. The output mode is shared by
// all channels: pass, invert, toggle-on-press and inverted toggle.
module debounced_inverter #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switch,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] LED,
  output logic [WIDTH-1:0] press
);

  typedef enum logic [1:0] {
    ModePass   = 2'b00,
    ModeInv    = 2'b01,
    ModeTog    = 2'b10,
    ModeTogInv = 2'b11
  } mode_e;

  // A new level is accepted on the edge where the counter already sits here.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] tog_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] led_next;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  mode_e            mode_sel;

  // mode comes from a static or synchronous source, so it is used directly.
  assign mode_sel = mode_e'(mode);

  // Two-flop synchroniser for the raw asynchronous switch levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

  // Debounce next state: count consecutive disagreeing cycles, accept on the last one.
  always_comb begin
    db_next = db;
    rise    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != db[i]) begin
        if (cnt[i] == CntMax) begin
          db_next[i] = sync2[i];
          // Only a 0->1 acceptance counts as a press.
          rise[i]    = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Toggle flips once per accepted press and survives mode changes.
  always_comb begin
    tog_next = tog ^ rise;
  end

  // Output selection from the values the state takes at this same edge.
  always_comb begin
    led_next = '0;
    unique case (mode_sel)
      ModePass:   led_next = db_next;
      ModeInv:    led_next = ~db_next;
      ModeTog:    led_next = tog_next;
      ModeTogInv: led_next = ~tog_next;
      default:    led_next = db_next;
    endcase
  end

  // Debouncer, toggle and output state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db    <= '0;
      tog   <= '0;
      LED   <= '0;
      press <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db    <= db_next;
      tog   <= tog_next;
      LED   <= led_next;
      press <= rise;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_debounced_inverter.sv
// Self-checking bench for debounced_inverter: a vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_debounced_inverter;

  localparam int W = 4;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw;
  logic [1:0]   mode;
  logic [W-1:0] led;
  logic [W-1:0] press;

  int checks = 0;
  int errors = 0;

  debounced_inverter #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .switch(sw),
    .mode  (mode),
    .LED   (led),
    .press (press)
  );

  always #5 clk = ~clk;

  // Reference model: level seen by the debouncer is the switch two edges ago;
  // disagreeing samples since the last acceptance are collected in a queue and
  // the level is accepted once D of them have piled up in a row.
  bit           m_s1  [W];
  bit           m_s2  [W];
  bit           m_db  [W];
  bit           m_tog [W];
  bit           pend  [W][$];
  logic [W-1:0] m_led;
  logic [W-1:0] m_press;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_s1[i]  = 1'b0;
      m_s2[i]  = 1'b0;
      m_db[i]  = 1'b0;
      m_tog[i] = 1'b0;
      pend[i].delete();
    end
    m_led   = '0;
    m_press = '0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < W; i++) begin
      bit seen;
      bit r;
      seen    = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = sw[i];
      r       = 1'b0;
      if (seen == m_db[i]) begin
        pend[i].delete();
      end else begin
        pend[i].push_back(seen);
        if (pend[i].size() == D) begin
          r       = seen;
          m_db[i] = seen;
          pend[i].delete();
        end
      end
      m_tog[i]   = m_tog[i] ^ r;
      m_press[i] = r;
      case (mode)
        2'b00:   m_led[i] = m_db[i];
        2'b01:   m_led[i] = ~m_db[i];
        2'b10:   m_led[i] = m_tog[i];
        default: m_led[i] = ~m_tog[i];
      endcase
    end
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check("led_model", 32'(led), 32'(m_led));
      check("press_model", 32'(press), 32'(m_press));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    check("reset_press", 32'(press), 32'h0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] sw;
    logic [1:0]   mode;
    int           n;
    logic [W-1:0] led;
    logic [W-1:0] press;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int found;
    int npress;
    logic [2:0] seq;
    bit saw_press;

    rst_n = 1'b0;
    sw    = '0;
    mode  = 2'b01;
    model_reset();

    // Table: from reset, D=16. Acceptance on the 18th edge counting the first sampling edge.
    tbl[0]  = '{4'b0000, 2'b01, 1,  4'b1111, 4'b0000};
    tbl[1]  = '{4'b0000, 2'b00, 1,  4'b0000, 4'b0000};
    tbl[2]  = '{4'b0001, 2'b00, 17, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0001, 2'b00, 1,  4'b0001, 4'b0001};
    tbl[4]  = '{4'b0001, 2'b00, 1,  4'b0001, 4'b0000};
    tbl[5]  = '{4'b0001, 2'b10, 1,  4'b0001, 4'b0000};
    tbl[6]  = '{4'b0001, 2'b11, 1,  4'b1110, 4'b0000};
    tbl[7]  = '{4'b0001, 2'b01, 1,  4'b1110, 4'b0000};
    tbl[8]  = '{4'b0011, 2'b00, 15, 4'b0001, 4'b0000};
    tbl[9]  = '{4'b0001, 2'b00, 5,  4'b0001, 4'b0000};
    tbl[10] = '{4'b0011, 2'b00, 17, 4'b0001, 4'b0000};
    tbl[11] = '{4'b0011, 2'b00, 1,  4'b0011, 4'b0010};
    tbl[12] = '{4'b0000, 2'b00, 17, 4'b0011, 4'b0000};
    tbl[13] = '{4'b0000, 2'b00, 1,  4'b0000, 4'b0000};
    tbl[14] = '{4'b0000, 2'b10, 1,  4'b0011, 4'b0000};

    do_reset();
    for (int v = 0; v < 15; v++) begin
      sw   = tbl[v].sw;
      mode = tbl[v].mode;
      step(tbl[v].n);
      check($sformatf("tbl%0d_led", v), 32'(led), 32'(tbl[v].led));
      check($sformatf("tbl%0d_press", v), 32'(press), 32'(tbl[v].press));
    end

    // Simultaneous rise on all channels in invert mode, then simultaneous release.
    do_reset();
    mode = 2'b01;
    sw   = '0;
    step(1);
    sw    = 4'b1111;
    found = -1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (led != 4'b1111) begin
        found = k;
        break;
      end
    end
    check("simul_fall_edge", 32'(found), 32'd17);
    check("simul_fall_led", 32'(led), 32'h0);
    check("simul_press", 32'(press), 32'hf);
    step(1);
    check("simul_press_once", 32'(press), 32'h0);
    sw        = 4'b0000;
    found     = -1;
    saw_press = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (press != '0) saw_press = 1'b1;
      if (led != 4'b0000) begin
        found = k;
        break;
      end
    end
    check("release_edge", 32'(found), 32'd17);
    check("release_led", 32'(led), 32'hf);
    check("release_no_press", 32'(saw_press), 32'd0);

    // Toggle mode: three clean presses on channel 2, then switch to inverted toggle.
    do_reset();
    mode = 2'b10;
    sw   = '0;
    step(1);
    npress = 0;
    seq    = '0;
    for (int p = 0; p < 3; p++) begin
      sw[2] = 1'b1;
      for (int k = 0; k < 80; k++) begin
        if (k == 40) sw[2] = 1'b0;
        step(1);
        if (press[2]) begin
          npress++;
          seq = {seq[1:0], led[2]};
        end
      end
    end
    check("tog_npress", 32'(npress), 32'd3);
    check("tog_seq", 32'(seq), 32'b101);
    mode = 2'b11;
    step(1);
    check("togn_led", 32'(led), 32'b1011);

    // Reset in the middle of a pending rise on channel 3 discards it.
    do_reset();
    mode = 2'b00;
    sw   = '0;
    step(2);
    sw = 4'b1000;
    step(10);
    do_reset();
    found = -1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (press[3]) begin
        found = k;
        break;
      end
    end
    check("rstmid_edge", 32'(found), 32'd17);
    check("rstmid_led", 32'(led), 32'b1000);

    // Randomized bouncy stimulus against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) sw = W'($urandom);
      if ($urandom_range(0, 3) == 0) sw[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
